// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Rounded clock cycles per oversample tick, never below 1.
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    int prod;
    int q;
    prod = baud * os;
    q    = (clk_freq + prod / 2) / prod;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-cycle pulse every DIV cycles
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver; optional even parity via UART_RX_PARITY_EN
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  parity_err_o
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);

  logic                  sync1_q, rxs_q, rxs_prev_q;
  uart_rx_state_e        state_q, state_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [1:0]            samp_q, samp_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  tick, tick_clear, bit_mid, bit_end, maj, commit, xfer;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  perr_q, perr_d;
  logic                  par_bad;
`endif

  assign tick_clear = (state_q == IDLE) || (state_q == BREAK);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (tick_clear),
    .tick_o  (tick)
  );

  // Two older samples plus the current one cover scnt = MID-2 .. MID.
  assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);
  assign bit_mid = tick && (scnt_q == S_MID);
  assign bit_end = tick && (scnt_q == S_LAST);
`ifdef UART_RX_PARITY_EN
  assign par_bad = (^frame_q) ^ par_q;
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    samp_d  = samp_q;
    commit  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (tick) begin
      samp_d = {samp_q[0], rxs_q};
      scnt_d = bit_end ? '0 : scnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        scnt_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = START;
      end
      START: begin
        if (bit_mid && maj) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_mid) frame_d[idx_q] = maj;
        if (bit_end) begin
          if (idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_mid) par_d = maj;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Return to IDLE at mid-stop so the next start edge is never missed.
        if (bit_mid) begin
          if (maj) begin
`ifdef UART_RX_PARITY_EN
            commit = !par_bad;
            perr_d = par_bad;
`else
            commit = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        scnt_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer = valid_q && ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (xfer) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      if (valid_q && !ready_i) begin
        ovr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = frame_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      scnt_q     <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      samp_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rx_i;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      samp_q     <= samp_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized self-checking bench for uart_rx_os with a frame-level model
module tb_uart_rx_os;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int DW       = 8;
  localparam int BITCLK   = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_i = 1'b1;
  logic          ready_i = 1'b1;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          parity_err_o;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  bit          exp_ovr = 1'b0;
  int          exp_ferr = 0, exp_perr = 0;
  int          ferr_seen = 0, perr_seen = 0;
  int          hi_len = 0, rise_cyc = 0, last_start = 0;
  logic [7:0]  last_data = 8'h00;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Model: whenever valid_o is high, data_o must be the oldest undelivered frame.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_valid = 1'b0;
    end else begin
      if (frame_err_o) ferr_seen++;
      if (parity_err_o) perr_seen++;
      if (valid_o) begin
        hi_len++;
        if (!prev_valid) begin
          rise_cyc  = cyc;
          last_data = data_o;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data %0h expected no frame", data_o);
        end else begin
          check("data_vs_model", {24'd0, data_o}, {24'd0, exp_q[0]});
          if (ready_i) void'(exp_q.pop_front());
        end
      end
      prev_valid = valid_o;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; abort_bit >= 0 pulses rst_i mid-way through that bit and abandons the frame.
  task automatic send(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                      input bit noisy, input int abort_bit);
    logic [11:0] fr;
    int          nb;
    bit          good, drop, spike;
    int          pos;
    fr    = '0;
    fr[0] = 1'b0;
    for (int k = 0; k < DW; k++) fr[k+1] = b[k];
`ifdef UART_RX_PARITY_EN
    fr[DW+1] = (^b) ^ par_flip;
    fr[DW+2] = stop_bit;
    nb = DW + 3;
`else
    fr[DW+1] = stop_bit;
    nb = DW + 2;
`endif
    if (abort_bit < 0) begin
`ifdef UART_RX_PARITY_EN
      good = stop_bit && !par_flip;
`else
      good = stop_bit;
`endif
      drop = (exp_q.size() != 0) && !ready_i;
      if (good && !drop) exp_q.push_back(b);
      if (good && drop) exp_ovr = 1'b1;
      if (!stop_bit) exp_ferr++;
      else if (!good) exp_perr++;
    end
    last_start = cyc + 1;
    for (int i = 0; i < nb; i++) begin
      spike = noisy && (i >= 1) && (i <= nb - 2) && ($urandom_range(0, 1) == 1);
      pos   = $urandom_range(2, 13);
      for (int c = 0; c < BITCLK; c++) begin
        if (abort_bit == i && c == 8) begin
          rst_i = 1'b1;
          #1;
          check("rst_valid", {31'd0, valid_o}, 32'd0);
          check("rst_data", {24'd0, data_o}, 32'd0);
          check("rst_overrun", {31'd0, overrun_o}, 32'd0);
          check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
          exp_q.delete();
          exp_ovr = 1'b0;
          hi_len  = 0;
          @(posedge clk);
          #1;
          rst_i = 1'b0;
          rx_i  = 1'b1;
          return;
        end
        rx_i = (spike && c == pos) ? ~fr[i] : fr[i];
        step(1);
      end
    end
  endtask

  initial begin
    int f0, p0, lat;
    logic [7:0] rb;
    bit bad, pf;

    step(3);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_data", {24'd0, data_o}, 32'd0);
    check("reset_ferr", {31'd0, frame_err_o}, 32'd0);
    check("reset_overrun", {31'd0, overrun_o}, 32'd0);
    check("reset_perr", {31'd0, parity_err_o}, 32'd0);
    rst_i = 1'b0;
    step(20);

    hi_len = 0;
    send(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    step(40);
    lat = rise_cyc - last_start;
    checks++;
    if (lat < 152 || lat > 156) begin
      errors++;
      $display("FAIL t1_latency: got %0d expected 152..156", lat);
    end
    check("t1_valid_cycles", hi_len, 1);
    check("t1_data_literal", {24'd0, last_data}, 32'hA5);
    check("t1_no_ferr", ferr_seen, 0);

    hi_len = 0;
    rx_i = 1'b0;
    step(4);
    rx_i = 1'b1;
    step(48);
    check("t2_glitch_no_valid", hi_len, 0);
    send(8'h3C, 1'b1, 1'b0, 1'b0, -1);
    step(40);
    check("t2_data_literal", {24'd0, last_data}, 32'h3C);

    f0 = ferr_seen;
    hi_len = 0;
    send(8'h55, 1'b0, 1'b0, 1'b0, -1);
    step(40 * BITCLK);
    check("t3_one_ferr", ferr_seen - f0, 1);
    check("t3_no_valid", hi_len, 0);
    rx_i = 1'b1;
    step(32);
    send(8'h81, 1'b1, 1'b0, 1'b0, -1);
    step(40);
    check("t3_data_literal", {24'd0, last_data}, 32'h81);

    ready_i = 1'b0;
    send(8'h11, 1'b1, 1'b0, 1'b0, -1);
    step(2);
    send(8'h22, 1'b1, 1'b0, 1'b0, -1);
    step(40);
    check("t4_valid_held", {31'd0, valid_o}, 32'd1);
    check("t4_data_literal", {24'd0, data_o}, 32'h11);
    check("t4_overrun_model", {31'd0, overrun_o}, {31'd0, exp_ovr});
    check("t4_overrun_literal", {31'd0, overrun_o}, 32'd1);
    ready_i = 1'b1;
    step(1);
    exp_ovr = 1'b0;
    check("t4_valid_cleared", {31'd0, valid_o}, 32'd0);
    check("t4_overrun_cleared", {31'd0, overrun_o}, 32'd0);

    ready_i = 1'b0;
    send(8'h33, 1'b1, 1'b0, 1'b0, -1);
    step(20);
    check("t5_pending_valid", {31'd0, valid_o}, 32'd1);
    send(8'h77, 1'b1, 1'b0, 1'b0, 5);
    ready_i = 1'b1;
    step(12 * BITCLK);
    check("t5_no_valid_after_rst", hi_len, 0);
    send(8'h12, 1'b1, 1'b0, 1'b0, -1);
    step(40);
    check("t5_data_literal", {24'd0, last_data}, 32'h12);

`ifdef UART_RX_PARITY_EN
    p0 = perr_seen;
    send(8'h07, 1'b1, 1'b0, 1'b0, -1);
    step(40);
    check("t6_par_ok_data", {24'd0, last_data}, 32'h07);
    hi_len = 0;
    send(8'h07, 1'b1, 1'b1, 1'b0, -1);
    step(40);
    check("t6_perr_pulse", perr_seen - p0, 1);
    check("t6_no_valid", hi_len, 0);
`else
    p0 = perr_seen;
`endif

    for (int n = 0; n < 40; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      pf  = ($urandom_range(0, 5) == 0);
`else
      pf  = 1'b0;
`endif
      send(rb, !bad, pf, 1'b1, -1);
      if (bad) begin
        step($urandom_range(1, 3) * BITCLK);
        rx_i = 1'b1;
        step(20);
      end else begin
        step($urandom_range(0, 20));
      end
    end
    step(40);

    check("end_queue_drained", exp_q.size(), 0);
    check("end_ferr_count", ferr_seen, exp_ferr);
    check("end_perr_count", perr_seen, exp_perr);
    check("end_perr_delta", perr_seen - p0, exp_perr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
